// File: rtl/life_gen_sequencer.sv
// Generation sequencer for the 8x8 toroidal Game of Life datapath.
// Holds the current grid, drives it to the combinational engine, commits
// generations on a tick or a step, and hands each committed grid to the
// display over a valid/ready link. Halts on a generation limit or still life.
module life_gen_sequencer #(
  parameter int unsigned TICKS_PER_GEN = 12_000_000,
  parameter int unsigned GEN_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [63:0]       load_grid,
  input  logic [GEN_W-1:0]  load_max,
  output logic              load_ready,
  input  logic              cmd_run,
  input  logic              cmd_pause,
  input  logic              cmd_step,
  output logic [63:0]       eng_grid,
  input  logic [63:0]       eng_next,
  output logic              frame_valid,
  output logic [63:0]       frame_data,
  input  logic              frame_ready,
  output logic [GEN_W-1:0]  gen_count,
  output logic [1:0]        state,
  output logic              done,
  output logic              stable
);

  localparam int unsigned TW = (TICKS_PER_GEN > 1) ? $clog2(TICKS_PER_GEN) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_GEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_PAUSED = 2'b10,
    S_HALT   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       grid_q, grid_d;
  logic [63:0]       frame_data_q, frame_data_d;
  logic              frame_valid_q, frame_valid_d;
  logic [GEN_W-1:0]  gen_count_q, gen_count_d;
  logic [GEN_W-1:0]  limit_q, limit_d;
  logic              done_q, done_d;
  logic              stable_q, stable_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic              gen_due_q, gen_due_d;
  logic              step_pend_q, step_pend_d;
  logic              commit;
  logic              load_acc;

  assign load_ready  = (state_q != S_RUN);
  assign eng_grid    = grid_q;
  assign frame_valid = frame_valid_q;
  assign frame_data  = frame_data_q;
  assign gen_count   = gen_count_q;
  assign state       = state_q;
  assign done        = done_q;
  assign stable      = stable_q;

  // Next-state: load, command handling, tick counting and commit evaluation
  always_comb begin
    state_d       = state_q;
    grid_d        = grid_q;
    frame_data_d  = frame_data_q;
    frame_valid_d = frame_valid_q;
    gen_count_d   = gen_count_q;
    limit_d       = limit_q;
    done_d        = done_q;
    stable_d      = stable_q;
    tick_d        = tick_q;
    gen_due_d     = gen_due_q;
    step_pend_d   = step_pend_q;
    commit        = 1'b0;
    load_acc      = load_valid && load_ready;

    if (frame_valid_q && frame_ready) begin
      frame_valid_d = 1'b0;
    end

    if (load_acc) begin
      grid_d        = load_grid;
      frame_data_d  = load_grid;
      frame_valid_d = 1'b1;
      gen_count_d   = '0;
      limit_d       = load_max;
      done_d        = 1'b0;
      stable_d      = 1'b0;
      tick_d        = '0;
      gen_due_d     = 1'b0;
      step_pend_d   = 1'b0;
      state_d       = S_PAUSED;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (cmd_pause) begin
            state_d   = S_PAUSED;
            gen_due_d = 1'b0;
            tick_d    = '0;
          end else if (gen_due_q && frame_valid_q) begin
            // Commit blocked by an undelivered frame: park the counter at 0
            tick_d = '0;
          end else begin
            if (gen_due_q) begin
              commit    = 1'b1;
              gen_due_d = 1'b0;
            end
            // A terminal count in the commit cycle re-arms gen_due (1-tick period)
            if (tick_q == TICK_LAST) begin
              tick_d    = '0;
              gen_due_d = 1'b1;
            end else begin
              tick_d = tick_q + TW'(1);
            end
          end
        end
        S_PAUSED: begin
          if (cmd_pause) begin
            step_pend_d = 1'b0;
          end else if (cmd_step || step_pend_q) begin
            if (frame_valid_q) begin
              step_pend_d = 1'b1;
            end else begin
              commit      = 1'b1;
              step_pend_d = 1'b0;
            end
          end else if (cmd_run) begin
            state_d   = S_RUN;
            tick_d    = '0;
            gen_due_d = 1'b0;
          end
        end
        default: ;
      endcase

      if (commit) begin
        if (eng_next == grid_q) begin
          stable_d  = 1'b1;
          state_d   = S_HALT;
          gen_due_d = 1'b0;
        end else begin
          grid_d        = eng_next;
          frame_data_d  = eng_next;
          frame_valid_d = 1'b1;
          if (gen_count_q != '1) begin
            gen_count_d = gen_count_q + GEN_W'(1);
          end
          if ((limit_q != '0) && (gen_count_d == limit_q)) begin
            done_d    = 1'b1;
            state_d   = S_HALT;
            gen_due_d = 1'b0;
          end
        end
      end
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grid_q        <= '0;
      frame_data_q  <= '0;
      frame_valid_q <= 1'b0;
      gen_count_q   <= '0;
      limit_q       <= '0;
      done_q        <= 1'b0;
      stable_q      <= 1'b0;
      tick_q        <= '0;
      gen_due_q     <= 1'b0;
      step_pend_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grid_q        <= grid_d;
      frame_data_q  <= frame_data_d;
      frame_valid_q <= frame_valid_d;
      gen_count_q   <= gen_count_d;
      limit_q       <= limit_d;
      done_q        <= done_d;
      stable_q      <= stable_d;
      tick_q        <= tick_d;
      gen_due_q     <= gen_due_d;
      step_pend_q   <= step_pend_d;
    end
  end

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Bench for life_gen_sequencer: a Game of Life engine model feeds eng_next,
// a behavioural model predicts every output each cycle, directed scenarios
// pin known patterns, then randomized traffic exercises the control paths.
module tb_life_gen_sequencer;

  localparam int T = 4;

  localparam logic [63:0] BLINK_H = 64'h00000038_00000000;
  localparam logic [63:0] BLINK_V = 64'h00001010_10000000;
  localparam logic [63:0] BLOCK   = 64'h00001818_00000000;
  localparam logic [63:0] GLIDER  = 64'h4020E000_00000000;

  logic        clk = 1'b0;
  logic        rst, load_valid, load_ready, cmd_run, cmd_pause, cmd_step;
  logic [63:0] load_grid, eng_grid, eng_next, frame_data;
  logic [15:0] load_max, gen_count;
  logic        frame_valid, frame_ready, done, stable;
  logic [1:0]  state;

  int vectors = 0;
  int miscompares = 0;
  int frames = 0;

  always #5 clk = ~clk;

  life_gen_sequencer #(.TICKS_PER_GEN(T), .GEN_W(16)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_grid(load_grid),
    .load_max(load_max), .load_ready(load_ready), .cmd_run(cmd_run),
    .cmd_pause(cmd_pause), .cmd_step(cmd_step), .eng_grid(eng_grid),
    .eng_next(eng_next), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_ready(frame_ready), .gen_count(gen_count), .state(state),
    .done(done), .stable(stable)
  );

  // Torus Game of Life, bit 63-(8*row+col)
  function automatic logic [63:0] life(input logic [63:0] g);
    logic [63:0] r;
    r = '0;
    for (int rr = 0; rr < 8; rr++) begin
      for (int cc = 0; cc < 8; cc++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0)
              n += int'(g[63 - 8*((rr+dr+8)%8) - ((cc+dc+8)%8)]);
          end
        end
        r[63-8*rr-cc] = (n == 3) || (g[63-8*rr-cc] && n == 2);
      end
    end
    return r;
  endfunction

  assign eng_next = life(eng_grid);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // state codes: 0 idle, 1 run, 2 paused, 3 halt
  int          m_st;
  logic [63:0] m_grid, m_fd;
  bit          m_fv, m_done, m_stable, m_due, m_pend;
  logic [15:0] m_gen, m_lim;
  int          cyc = 0;
  int          m_zero = 0;   // cycle at which the tick phase restarted
  bit          model_ok = 0;

  task automatic model_step();
    logic [63:0] nx;
    bit opp, hit, fv0;
    opp = 0; hit = 0;
    fv0 = m_fv;
    if (rst) begin
      m_st = 0; m_grid = '0; m_fd = '0; m_fv = 0; m_done = 0; m_stable = 0;
      m_due = 0; m_pend = 0; m_gen = '0; m_lim = '0; m_zero = cyc + 1;
      model_ok = 1;
    end else if (model_ok) begin
      if (m_fv && frame_ready) m_fv = 0;
      if (load_valid && m_st != 1) begin
        m_grid = load_grid; m_fd = load_grid; m_fv = 1; m_gen = '0;
        m_lim = load_max; m_done = 0; m_stable = 0; m_due = 0; m_pend = 0; m_st = 2;
      end else begin
        if (m_st == 1) begin
          if (cmd_pause) begin
            m_st = 2; m_due = 0;
          end else if (m_due && fv0) begin
            m_zero = cyc + 1;
          end else begin
            opp = m_due;
            hit = ((cyc - m_zero) % T) == T - 1;
            if (opp) m_due = 0;
            if (hit) m_due = 1;
          end
        end else if (m_st == 2) begin
          if (cmd_pause) m_pend = 0;
          else if (cmd_step || m_pend) begin
            if (fv0) m_pend = 1;
            else begin opp = 1; m_pend = 0; end
          end else if (cmd_run) begin
            m_st = 1; m_zero = cyc + 1; m_due = 0;
          end
        end
        if (opp) begin
          nx = life(m_grid);
          if (nx == m_grid) begin
            m_stable = 1; m_st = 3;
          end else begin
            m_grid = nx; m_fd = nx; m_fv = 1;
            if (m_gen != 16'hFFFF) m_gen++;
            if (m_lim != 0 && m_gen == m_lim) begin m_done = 1; m_st = 3; end
          end
        end
      end
    end
    cyc++;
  endtask

  // Compare every cycle, then advance the model with the inputs for the next edge
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("load_ready",  64'(load_ready),  64'(m_st != 1));
        check("eng_grid",    eng_grid,         m_grid);
        check("frame_valid", 64'(frame_valid), 64'(m_fv));
        check("frame_data",  frame_data,       m_fd);
        check("gen_count",   64'(gen_count),   64'(m_gen));
        check("state",       64'(state),       64'(m_st));
        check("done",        64'(done),        64'(m_done));
        check("stable",      64'(stable),      64'(m_stable));
      end
      if (model_ok && frame_valid && frame_ready) frames++;
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_cmd(input bit r, input bit p, input bit s);
    cmd_run = r; cmd_pause = p; cmd_step = s;
    nxt();
    cmd_run = 0; cmd_pause = 0; cmd_step = 0;
  endtask

  task automatic do_load(input logic [63:0] g, input logic [15:0] m);
    load_valid = 1; load_grid = g; load_max = m;
    nxt();
    load_valid = 0;
  endtask

  task automatic wait_gen(input logic [15:0] g, input int budget, output int n);
    n = 0;
    while (gen_count != g && n < budget) begin nxt(); n++; end
  endtask

  initial begin
    int n;
    logic [15:0] g;
    logic [63:0] fd;
    rst = 1; load_valid = 0; load_grid = '0; load_max = '0;
    cmd_run = 0; cmd_pause = 0; cmd_step = 0; frame_ready = 1;
    nxt(); nxt();
    check("reset_state", 64'(state), 64'd0);
    check("reset_load_ready", 64'(load_ready), 64'd1);
    rst = 0;

    // Blinker
    do_load(BLINK_H, 16'd0);
    check("blink_load_state", 64'(state), 64'd2);
    check("blink_load_frame", frame_data, BLINK_H);
    pulse_cmd(1, 0, 0);
    wait_gen(16'd1, 40, n);
    check("blink_gen1", 64'(gen_count), 64'd1);
    check("blink_grid1", eng_grid, BLINK_V);
    check("blink_frame1", frame_data, BLINK_V);
    wait_gen(16'd2, 40, n);
    check("blink_gen2", 64'(gen_count), 64'd2);
    check("blink_period", 64'(n), 64'd4);
    check("blink_grid2", eng_grid, BLINK_H);
    pulse_cmd(0, 1, 0);
    check("pause_state", 64'(state), 64'd2);

    // Still life
    do_load(BLOCK, 16'd0);
    pulse_cmd(0, 0, 1);
    nxt(); nxt(); nxt();
    check("still_stable", 64'(stable), 64'd1);
    check("still_state", 64'(state), 64'd3);
    check("still_gen", 64'(gen_count), 64'd0);
    check("still_frame", frame_data, BLOCK);
    check("still_fv", 64'(frame_valid), 64'd0);

    // Generation limit with a glider
    frames = 0;
    do_load(GLIDER, 16'd3);
    pulse_cmd(1, 0, 0);
    n = 0;
    while (state != 2'd3 && n < 100) begin nxt(); n++; end
    nxt(); nxt(); nxt();
    check("limit_state", 64'(state), 64'd3);
    check("limit_done", 64'(done), 64'd1);
    check("limit_gen", 64'(gen_count), 64'd3);
    check("limit_frames", 64'(frames), 64'd4);

    // Backpressure
    do_load(BLINK_H, 16'd0);
    nxt();
    pulse_cmd(1, 0, 0);
    wait_gen(16'd1, 40, n);
    frame_ready = 0;
    n = 0;
    while (!frame_valid && n < 40) begin nxt(); n++; end
    g = gen_count; fd = frame_data;
    repeat (20) nxt();
    check("bp_fv", 64'(frame_valid), 64'd1);
    check("bp_gen_frozen", 64'(gen_count), 64'(g));
    check("bp_data_frozen", frame_data, fd);
    frame_ready = 1;
    wait_gen(g + 16'd1, 40, n);
    check("bp_resume_gen", 64'(gen_count), 64'(g + 16'd1));
    check("bp_resume_data", frame_data, life(fd));

    // Commands
    pulse_cmd(0, 1, 0);
    nxt(); nxt();
    g = gen_count;
    pulse_cmd(0, 0, 1);
    nxt(); nxt();
    check("step_gen", 64'(gen_count), 64'(g + 16'd1));
    check("step_state", 64'(state), 64'd2);
    pulse_cmd(1, 1, 0);
    check("run_pause_state", 64'(state), 64'd2);
    do_load(BLOCK, 16'd0);
    nxt(); nxt();
    pulse_cmd(0, 0, 1);
    nxt(); nxt();
    check("halt_before_load", 64'(state), 64'd3);
    load_valid = 1; load_grid = BLINK_H; load_max = 16'd0; cmd_run = 1;
    nxt();
    load_valid = 0; cmd_run = 0;
    check("load_run_state", 64'(state), 64'd2);
    check("load_run_gen", 64'(gen_count), 64'd0);

    // Reset mid-RUN with a frame pending
    frame_ready = 0;
    pulse_cmd(1, 0, 0);
    repeat (6) nxt();
    check("pre_rst_fv", 64'(frame_valid), 64'd1);
    rst = 1;
    nxt();
    check("rst_grid", eng_grid, 64'd0);
    check("rst_fv", 64'(frame_valid), 64'd0);
    check("rst_fd", frame_data, 64'd0);
    check("rst_gen", 64'(gen_count), 64'd0);
    check("rst_state", 64'(state), 64'd0);
    check("rst_flags", 64'({done, stable}), 64'd0);
    check("rst_load_ready", 64'(load_ready), 64'd1);
    rst = 0; frame_ready = 1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 599) == 0);
      load_valid  = ($urandom_range(0, 39) == 0);
      load_grid   = {$urandom, $urandom} & {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) load_grid = ($urandom_range(0, 1) != 0) ? GLIDER : BLINK_H;
      load_max    = 16'($urandom_range(0, 5));
      cmd_run     = ($urandom_range(0, 7) == 0);
      cmd_pause   = ($urandom_range(0, 24) == 0);
      cmd_step    = ($urandom_range(0, 9) == 0);
      frame_ready = ($urandom_range(0, 9) < 7);
      nxt();
    end
    rst = 0; load_valid = 0; cmd_run = 0; cmd_pause = 0; cmd_step = 0;
    repeat (4) nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
